// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// field codes, ALU operation codes, datapath mux encodings and condition codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    // op field (instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // funct[4:1] data-processing command codes
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Destination register number that means "write the PC"
    localparam logic [3:0] RD_PC = 4'd15;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Datapath mux encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Condition codes (instr[31:28])
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Map a data-processing command to an ALU operation; unknown commands add.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Condition evaluation: ARM condition code against the registered {N,Z,C,V}.
module cond_check
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags;

    // Pure decode of the condition table
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: main FSM, flags register and datapath
// control decode. Optional macro MCTRL_WAIT_EN adds the mem_rdy input and
// stretches FETCH/MEMRD/MEMWR until memory reports completion.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
`ifdef MCTRL_WAIT_EN
    input  logic        mem_rdy,
`endif
    output logic        pc_we,
    output logic        ir_we,
    output logic        adr_src,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctrl,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags
);

    state_e      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        cond_ex;
    logic        mem_ready;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [1:0]  dp_alu;
    logic        unused_instr_bits;

`ifdef MCTRL_WAIT_EN
    assign mem_ready = mem_rdy;
`else
    assign mem_ready = 1'b1;
`endif

    assign op                = instr[27:26];
    assign funct             = instr[25:20];
    assign rd                = instr[15:12];
    assign dp_alu            = alu_decode(funct[4:1]);
    assign flags             = flags_q;
    assign unused_instr_bits = ^{instr[19:16], instr[11:0]};

    cond_check u_cond_check (
        .cond    (instr[31:28]),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // State and flags registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic: one transition per clock, memory states may stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXEC_I : S_EXEC_R;
                    OP_B:    state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Flags capture at the end of a flag-setting, condition-passing execute;
    // logical operations leave C and V untouched
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXEC_R || state_q == S_EXEC_I) && funct[0] && cond_ex) begin
            if (dp_alu == ALU_ADD || dp_alu == ALU_SUB) begin
                flags_d = alu_flags;
            end else begin
                flags_d[3:2] = alu_flags[3:2];
            end
        end
    end

    // Control outputs decoded from state, instr and registered flags only;
    // everything is forced low while reset is held
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        adr_src    = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_ctrl   = ALU_ADD;
        imm_src    = op;
        reg_src    = {(op == OP_MEM) && !funct[0], op == OP_B};
        case (state_q)
            S_FETCH: begin
                ir_we      = mem_ready;
                pc_we      = mem_ready;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
            end
            S_MEMADR: alu_src_b = SRCB_IMM;
            S_MEMRD:  adr_src   = 1'b1;
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_we     = cond_ex;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_we  = cond_ex;
            end
            S_EXEC_R: alu_ctrl = dp_alu;
            S_EXEC_I: begin
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dp_alu;
            end
            S_ALUWB: begin
                if (rd == RD_PC) pc_we  = cond_ex;
                else             reg_we = cond_ex;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_we      = cond_ex;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            adr_src    = 1'b0;
            mem_we     = 1'b0;
            reg_we     = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_ctrl   = 2'b00;
            imm_src    = 2'b00;
            reg_src    = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: spec vector table, reset and wait
// corner sequences, and random instructions against a phase-list model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
`ifdef MCTRL_WAIT_EN
    logic        mem_rdy;
`endif
    logic        pc_we, ir_we, adr_src, mem_we, reg_we;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, reg_src;
    logic [3:0]  flags;
    logic [22:0] dut_vec;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .alu_flags  (alu_flags),
`ifdef MCTRL_WAIT_EN
        .mem_rdy    (mem_rdy),
`endif
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .adr_src    (adr_src),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .flags      (flags)
    );

    assign dut_vec = {pc_we, ir_we, adr_src, mem_we, reg_we, result_src,
                      alu_src_a, alu_src_b, alu_ctrl, imm_src, reg_src, flags};

    int         checks = 0;
    int         errors = 0;
    logic [3:0] mflags;       // reference flags
    string      plan[$];      // reference phase sequence of the current instruction

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  af;
        int          lat;
        logic [3:0]  flg;
        int          pcn;
        int          rwn;
        int          mwn;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ARM condition table
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Phase list an instruction walks through, starting at FETCH
    function automatic void make_plan(input logic [31:0] ins);
        plan.delete();
        plan.push_back("FETCH");
        plan.push_back("DECODE");
        case (ins[27:26])
            2'b01: begin
                plan.push_back("MEMADR");
                if (ins[20]) begin
                    plan.push_back("MEMRD");
                    plan.push_back("MEMWB");
                end else begin
                    plan.push_back("MEMWR");
                end
            end
            2'b00: begin
                plan.push_back(ins[25] ? "EXEC_I" : "EXEC_R");
                plan.push_back("ALUWB");
            end
            2'b10: plan.push_back("BRANCH");
            default: ;
        endcase
    endfunction

    // Expected output bundle for one phase
    function automatic logic [22:0] expect_vec(input string ph, input logic [31:0] ins, input logic [3:0] f);
        logic       pc, ir, adr, mw, rw, ce;
        logic [1:0] res, a, b, alu;
        logic [3:0] cmd;
        pc = 0; ir = 0; adr = 0; mw = 0; rw = 0;
        res = 0; a = 0; b = 0; alu = 0;
        ce  = cond_ok(ins[31:28], f);
        cmd = ins[24:21];
        if (ph == "FETCH") begin
            ir = 1; pc = 1; a = 2'b01; b = 2'b10; res = 2'b10;
        end else if (ph == "DECODE") begin
            a = 2'b01; b = 2'b10;
        end else if (ph == "MEMADR") begin
            b = 2'b01;
        end else if (ph == "MEMRD") begin
            adr = 1;
        end else if (ph == "MEMWB") begin
            res = 2'b01; rw = ce;
        end else if (ph == "MEMWR") begin
            adr = 1; mw = ce;
        end else if (ph == "EXEC_R" || ph == "EXEC_I") begin
            b   = (ph == "EXEC_I") ? 2'b01 : 2'b00;
            alu = (cmd == 4'b0010) ? 2'b01 : (cmd == 4'b0000) ? 2'b10 :
                  (cmd == 4'b1100) ? 2'b11 : 2'b00;
        end else if (ph == "ALUWB") begin
            if (ins[15:12] == 4'd15) pc = ce;
            else                     rw = ce;
        end else if (ph == "BRANCH") begin
            b = 2'b01; res = 2'b10; pc = ce;
        end
        return {pc, ir, adr, mw, rw, res, a, b, alu, ins[27:26],
                (ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10, f};
    endfunction

    // Reference flag update when an execute phase completes
    function automatic void model_step(input string ph, input logic [31:0] ins, input logic [3:0] af);
        if ((ph == "EXEC_R" || ph == "EXEC_I") && ins[20] && cond_ok(ins[31:28], mflags)) begin
            if (ins[24:21] == 4'b0000 || ins[24:21] == 4'b1100) mflags[3:2] = af[3:2];
            else                                                  mflags      = af;
        end
    endfunction

    // Run one instruction from a FETCH cycle (called just after a negedge)
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                             output int lat, output int pcn, output int rwn, output int mwn);
        bit done;
        make_plan(ins);
        instr = ins;
        alu_flags = af;
        #1;
        lat = 0; pcn = 0; rwn = 0; mwn = 0; done = 0;
        for (int k = 0; k < 12 && !done; k++) begin
            if (k > 0) begin
                @(posedge clk);
                if (k - 1 < plan.size()) model_step(plan[k-1], ins, af);
                @(negedge clk);
                if (ir_we) begin
                    lat = k;
                    done = 1;
                end
            end
            if (!done) begin
                pcn += int'(pc_we);
                rwn += int'(reg_we);
                mwn += int'(mem_we);
                if (k < plan.size())
                    chk($sformatf("%s_%h", plan[k], ins), 32'(dut_vec), 32'(expect_vec(plan[k], ins, mflags)));
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout_%h: no return to FETCH within 12 cycles, required %0d", ins, plan.size());
        end else begin
            chk($sformatf("latency_%h", ins), 32'(lat), 32'(plan.size()));
        end
        $display("instr %h alu_flags %b latency %0d pc_we %0d reg_we %0d mem_we %0d flags %b",
                 ins, af, lat, pcn, rwn, mwn, flags);
    endtask

    initial begin
        int lat, pcn, rwn, mwn;
        logic [31:0] str_i;

        tbl[0]  = '{32'hE591_2004, 4'b0000, 5, 4'b0000, 1, 1, 0}; // LDR
        tbl[1]  = '{32'hE090_1002, 4'b0110, 4, 4'b0110, 1, 1, 0}; // ADDS
        tbl[2]  = '{32'hE010_1002, 4'b1000, 4, 4'b1010, 1, 1, 0}; // ANDS: C,V hold
        tbl[3]  = '{32'hE090_1002, 4'b0100, 4, 4'b0100, 1, 1, 0}; // ADDS -> Z=1
        tbl[4]  = '{32'h1050_3000, 4'b0001, 4, 4'b0100, 1, 0, 0}; // SUBNE rd3, Z=1: no write
        tbl[5]  = '{32'hEA00_0002, 4'b1111, 3, 4'b0100, 2, 0, 0}; // B
        tbl[6]  = '{32'hE080_F002, 4'b1111, 4, 4'b0100, 2, 0, 0}; // ADD rd=15
        tbl[7]  = '{32'hE580_1000, 4'b0000, 4, 4'b0100, 1, 0, 1}; // STR
        tbl[8]  = '{32'hEC00_0000, 4'b0000, 2, 4'b0100, 1, 0, 0}; // op 11
        tbl[9]  = '{32'hE090_1002, 4'b0111, 4, 4'b0111, 1, 1, 0}; // ADDS
        tbl[10] = '{32'hE390_1000, 4'b1000, 4, 4'b1011, 1, 1, 0}; // ORRS imm: C,V hold
        tbl[11] = '{32'h0A00_0002, 4'b0000, 3, 4'b1011, 1, 0, 0}; // BEQ not taken
        tbl[12] = '{32'hE1F0_1000, 4'b0110, 4, 4'b0110, 1, 1, 0}; // unknown cmd adds

        // Reset state: everything low even with a branch in the IR
        rst_n = 1'b0;
        instr = 32'hEA00_0002;
        alu_flags = 4'b1111;
`ifdef MCTRL_WAIT_EN
        mem_rdy = 1'b1;
`endif
        mflags = 4'b0000;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;

        // Spec vector table
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].ins, tbl[i].af, lat, pcn, rwn, mwn);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].flg));
            chk($sformatf("tbl%0d_pc_we_count", i), 32'(pcn), 32'(tbl[i].pcn));
            chk($sformatf("tbl%0d_reg_we_count", i), 32'(rwn), 32'(tbl[i].rwn));
            chk($sformatf("tbl%0d_mem_we_count", i), 32'(mwn), 32'(tbl[i].mwn));
        end

        // Reset asserted in MEMWR: write drops at once, fetch restarts after release
        str_i = 32'hE580_1000;
        instr = str_i;
        #1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("memwr_mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_in_memwr", 32'(dut_vec), 32'd0);
        mflags = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_fetch", 32'(dut_vec), 32'(expect_vec("FETCH", str_i, mflags)));
        @(posedge clk);
        @(negedge clk);
        chk("release_decode", 32'(dut_vec), 32'(expect_vec("DECODE", str_i, mflags)));
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("release_back_to_fetch", 32'(ir_we), 32'd1);

`ifdef MCTRL_WAIT_EN
        // FETCH stalls on mem_rdy, then one single enable pulse
        instr = 32'hEC00_0000;
        mem_rdy = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("wait%0d_ir_pc", c), 32'({ir_we, pc_we}), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        mem_rdy = 1'b1;
        #1;
        chk("wait_release_ir_pc", 32'({ir_we, pc_we}), 32'b11);
        @(posedge clk);
        @(negedge clk);
        chk("wait_decode_ir_pc", 32'({ir_we, pc_we}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("wait_back_fetch", 32'(ir_we), 32'd1);
`endif

        // Random instructions against the reference model
        for (int r = 0; r < 300; r++) begin
            run_instr($urandom, 4'($urandom_range(0, 15)), lat, pcn, rwn, mwn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; one clock domain.
REQ-002 rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-003 instr  input  32  IR contents: cond[31:28], op[27:26], funct[25:20], rd[15:12].
REQ-004 alu_flags  input  4  {N,Z,C,V} produced by the ALU in the current cycle.
REQ-005 mem_rdy  input  1  memory access complete; port present only with MCTRL_WAIT_EN.
REQ-006 pc_we  output  1  PC register write enable.
REQ-007 ir_we  output  1  instruction register write enable.
REQ-008 adr_src  output  1  memory address select: 0=PC, 1=ALU result register.
REQ-009 mem_we  output  1  data memory write enable.
REQ-010 reg_we  output  1  register file write enable.
REQ-011 result_src  output  2  result select: 00=ALU result register, 01=read data, 10=ALU direct.
REQ-012 alu_src_a  output  2  ALU A select: 00=register A, 01=PC.
REQ-013 alu_src_b  output  2  ALU B select: 00=register B, 01=extended immediate, 10=constant 4.
REQ-014 alu_ctrl  output  2  ALU operation: 00=ADD, 01=SUB, 10=AND, 11=ORR.
REQ-015 imm_src  output  2  immediate format; equals op.
REQ-016 reg_src  output  2  {op==MEM and funct[0]==0, op==B}.
REQ-017 flags  output  4  registered {N,Z,C,V}.

Function
REQ-018 The FSM SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB and BRANCH, with one transition per clock.
REQ-019 FETCH SHALL assert ir_we=1 and pc_we=1 with adr_src=0, alu_src_a=01, alu_src_b=10, ADD and result_src=10, then go to DECODE.
REQ-020 DECODE SHALL drive alu_src_a=01, alu_src_b=10 and ADD, then branch on op:
- op 01 -> MEMADR.
- op 00 with funct[5]=0 -> EXEC_R.
- op 00 with funct[5]=1 -> EXEC_I.
- op 10 -> BRANCH.
- op 11 -> FETCH.
REQ-021 MEMADR SHALL drive alu_src_a=00, alu_src_b=01 and ADD, then go to MEMRD if funct[0]=1, else MEMWR.
REQ-022 MEMRD SHALL drive adr_src=1 and go to MEMWB; MEMWB SHALL drive result_src=01 and reg_we=cond_ex, then go to FETCH.
REQ-023 MEMWR SHALL drive adr_src=1 and mem_we=cond_ex, then go to FETCH.
REQ-024 EXEC_R and EXEC_I SHALL drive alu_src_a=00, with alu_src_b=00 in EXEC_R and 01 in EXEC_I, then go to ALUWB.
REQ-025 In EXEC_R and EXEC_I, alu_ctrl SHALL decode funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, any other value ADD.
REQ-026 ALUWB SHALL drive result_src=00 and go to FETCH:
- If rd!=15, reg_we=cond_ex and pc_we=0.
- If rd==15, pc_we=cond_ex and reg_we=0.
REQ-027 BRANCH SHALL drive alu_src_a=00, alu_src_b=01, ADD, result_src=10 and pc_we=cond_ex, then go to FETCH.
REQ-028 cond_ex SHALL be combinational from cond and the registered flags per the ARM condition table:
- EQ..LE as defined by ARM.
- 1110 always true.
- 1111 false.
REQ-029 At the end of EXEC_R or EXEC_I, when funct[0]=1 and cond_ex=1, the flags register SHALL update:
- ADD and SUB update all four flags from alu_flags.
- AND and ORR update N and Z only; C and V hold.
REQ-030 Every output not explicitly driven in a state SHALL be 0; the enables (pc_we, ir_we, mem_we, reg_we) SHALL be glitch-free decodes of state, instr and flags.
REQ-031 Latency from FETCH to the next FETCH SHALL be LDR 5, STR 4, DP 4, B 3 and op 11 2 cycles.

Reset
REQ-032 While rst_n=0: state=FETCH, flags=0000, all enables 0, all select and control outputs 00/0.
REQ-033 Reset asserted mid-instruction SHALL abort it immediately, with no write enable asserted from assertion onward; fetch SHALL restart on the first clock after deassertion.

Configuration
REQ-034 With MCTRL_WAIT_EN defined, mem_rdy SHALL exist, and FETCH, MEMRD and MEMWR SHALL hold while mem_rdy=0:
- ir_we and pc_we pulse only in the FETCH cycle where mem_rdy=1.
- mem_we stays asserted until mem_rdy=1.
REQ-035 Without MCTRL_WAIT_EN, mem_rdy SHALL be absent and every state SHALL last exactly one cycle.

Structure
REQ-036 The shared package SHALL hold: the state enum, the op/funct codes, the ALU codes, the result_src, alu_src_a and alu_src_b encodings, and the cond codes.
REQ-037 Condition evaluation SHALL be a sub-module cond_check (cond, flags -> cond_ex).

Verification
REQ-038 LDR instr=32'hE591_2004: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_we=1 only in MEMWB; 5 cycles.
REQ-039 ADDS with alu_flags=4'b0110 in EXEC: flags=0110 next cycle; a following ANDS with alu_flags=1000 gives flags=1010.
REQ-040 With Z=1, SUBNE to rd=3: reg_we stays 0 in ALUWB and flags are unchanged.
REQ-041 B instr=32'hEA00_0002: pc_we=1 in FETCH and BRANCH; 3 cycles; DP with rd=15: pc_we=1, reg_we=0 in ALUWB.
REQ-042 Reset asserted during MEMWR: mem_we drops within the reset cycle, and state=FETCH after release.
REQ-043 (MCTRL_WAIT_EN) mem_rdy=0 for 3 cycles in FETCH: state held, ir_we=pc_we=0, then a single 1-cycle pulse of ir_we and pc_we when mem_rdy=1.
